// File: rtl/hw_sig_seq_pkg.sv
// Shared types and constants for the signal sequencer: FSM state encoding,
// register map and software command codes.
package hw_sig_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BUSY  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   localparam logic [1:0] ADDR_CMD     = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CYCLES  = 2'd2;
   localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_START = 2'b01;
   localparam logic [1:0] CMD_ACK   = 2'b10;
   localparam logic [1:0] CMD_ABORT = 2'b11;

endpackage

// File: rtl/hw_sig_sequencer_if.sv
// Avalon-MM slave register bus of the signal sequencer.
interface hw_sig_sequencer_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/hw_sig_sequencer.sv
// Software-driven start/abort sequencer for an external engine, with a
// busy-cycle counter and a programmable completion timeout.
//
// state | meaning
// IDLE  | waiting for a START command
// START | one-cycle eng_start pulse, counter cleared
// BUSY  | engine running, counter advancing, abort/done/timeout watched
// DONE  | engine finished, waiting for ACK
// ERR   | timeout expired, waiting for ACK
module hw_sig_sequencer
   import hw_sig_seq_pkg::*;
#(
   parameter int                 CNT_W       = 16,
   parameter logic [CNT_W-1:0]   TIMEOUT_RST = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   hw_sig_sequencer_if.slave     bus,
   output logic                  eng_start,
   output logic                  eng_abort,
   input  logic                  eng_done,
   output logic [1:0]            to_sw_sig
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] timeout_q, timeout_d;
   logic             abort_pend_q, abort_pend_d;
   logic [1:0]       to_sw_sig_q, to_sw_sig_d;

   logic wr, cmd_wr, start_wr, ack_wr, abort_wr;
   logic unused_wdata;

   assign wr       = bus.chipselect && !bus.write_n;
   assign cmd_wr   = wr && (bus.address == ADDR_CMD);
   assign start_wr = cmd_wr && (bus.writedata[1:0] == CMD_START);
   assign ack_wr   = cmd_wr && (bus.writedata[1:0] == CMD_ACK);
   assign abort_wr = cmd_wr && (bus.writedata[1:0] == CMD_ABORT);
   assign unused_wdata = ^bus.writedata;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      timeout_d    = timeout_q;
      abort_pend_d = 1'b0;
      eng_start    = 1'b0;
      eng_abort    = 1'b0;

      if (wr && (bus.address == ADDR_TIMEOUT))
         timeout_d = bus.writedata[CNT_W-1:0];

      case (state_q)
         ST_IDLE: begin
            if (start_wr)
               state_d = ST_START;
         end
         ST_START: begin
            eng_start    = 1'b1;
            cnt_d        = '0;
            state_d      = ST_BUSY;
            // an abort arriving with the start pulse is replayed in BUSY
            abort_pend_d = abort_wr;
         end
         ST_BUSY: begin
            if (abort_wr || abort_pend_q) begin
               eng_abort = 1'b1;
               state_d   = ST_IDLE;
            end else if (eng_done) begin
               state_d = ST_DONE;
            end else if ((timeout_q != '0) && (cnt_q == timeout_q)) begin
               state_d = ST_ERR;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE, ST_ERR: begin
            if (ack_wr)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_DONE: to_sw_sig_d = 2'b01;
         ST_ERR:  to_sw_sig_d = 2'b10;
         default: to_sw_sig_d = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         timeout_q    <= TIMEOUT_RST;
         abort_pend_q <= 1'b0;
         to_sw_sig_q  <= 2'b00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         timeout_q    <= timeout_d;
         abort_pend_q <= abort_pend_d;
         to_sw_sig_q  <= to_sw_sig_d;
      end
   end

   assign to_sw_sig = to_sw_sig_q;

   always_comb begin
      bus.readdata = 32'h0;
      case (bus.address)
         ADDR_STATUS: bus.readdata = {26'h0,
                                      (state_q == ST_ERR),
                                      (state_q == ST_DONE),
                                      (state_q == ST_START) || (state_q == ST_BUSY),
                                      state_q};
         ADDR_CYCLES:  bus.readdata = 32'(cnt_q);
         ADDR_TIMEOUT: bus.readdata = 32'(timeout_q);
         default:      bus.readdata = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_hw_sig_sequencer.sv
// Directed scoreboard bench for hw_sig_sequencer: start/done, timeout, abort,
// deferred abort, done-vs-timeout tie, ignored commands and async reset.
module tb_hw_sig_sequencer;
   import hw_sig_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       eng_done = 1'b0;
   logic       eng_start, eng_abort;
   logic [1:0] to_sw_sig;

   hw_sig_sequencer_if bus();

   hw_sig_sequencer #(.CNT_W(16), .TIMEOUT_RST(16'hFFFF)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .eng_start (eng_start),
      .eng_abort (eng_abort),
      .eng_done  (eng_done),
      .to_sw_sig (to_sw_sig)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic expect_v(string tag, logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic got(logic [31:0] act);
      exp_t e;
      n_chk++;
      if (sb.size() == 0) begin
         $error("FAIL sb_empty: got %0h with nothing expected", act);
         return;
      end
      e = sb.pop_front();
      assert (act === e.val) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", e.tag, act, e.val);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wr(logic [1:0] a, logic [31:0] d);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.address    = a;
      bus.writedata  = d;
   endtask

   task automatic release_bus();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_write(logic [1:0] a, logic [31:0] d);
      drive_wr(a, d);
      tick();
      release_bus();
   endtask

   task automatic chk_rd(string tag, logic [1:0] a, logic [31:0] v);
      logic [31:0] d;
      expect_v(tag, v);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      bus.address    = a;
      #1;
      d = bus.readdata;
      bus.chipselect = 1'b0;
      got(d);
   endtask

   task automatic chk_sig(string tag, logic [31:0] act, logic [31:0] v);
      expect_v(tag, v);
      got(act);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();

      chk_rd("rst_status", ADDR_STATUS, 32'h0);
      chk_rd("rst_cycles", ADDR_CYCLES, 32'h0);
      chk_rd("rst_timeout", ADDR_TIMEOUT, 32'hFFFF);
      chk_sig("rst_tosw", to_sw_sig, 0);
      chk_sig("rst_start", eng_start, 0);
      chk_sig("rst_abort", eng_abort, 0);
      chk_rd("cmd_reads_0", ADDR_CMD, 32'h0);

      // normal completion after 5 busy cycles
      bus_write(ADDR_CMD, 32'h1);
      chk_sig("start_pulse", eng_start, 1);
      chk_rd("status_start", ADDR_STATUS, 32'h09);
      tick();
      chk_sig("start_once", eng_start, 0);
      repeat (5) tick();
      chk_rd("cycles_busy", ADDR_CYCLES, 32'd5);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk_sig("tosw_done", to_sw_sig, 1);
      chk_rd("cycles_done", ADDR_CYCLES, 32'd5);
      chk_rd("status_done", ADDR_STATUS, 32'h13);

      // START in DONE ignored, ACK returns to IDLE, counter held
      bus_write(ADDR_CMD, 32'h1);
      chk_sig("no_start_in_done", eng_start, 0);
      chk_rd("status_still_done", ADDR_STATUS, 32'h13);
      bus_write(ADDR_CMD, 32'h2);
      chk_rd("status_ack", ADDR_STATUS, 32'h0);
      chk_sig("tosw_ack", to_sw_sig, 0);
      chk_rd("cycles_held", ADDR_CYCLES, 32'd5);

      // eng_done in IDLE ignored
      eng_done = 1'b1;
      tick();
      chk_sig("idle_done_no_start", eng_start, 0);
      eng_done = 1'b0;
      tick();
      chk_rd("idle_done_status", ADDR_STATUS, 32'h0);
      chk_sig("idle_done_tosw", to_sw_sig, 0);

      // timeout
      bus_write(ADDR_TIMEOUT, 32'h3);
      chk_rd("timeout_rd", ADDR_TIMEOUT, 32'h3);
      bus_write(ADDR_CMD, 32'h1);
      tick();
      repeat (3) tick();
      chk_rd("status_busy_cnt3", ADDR_STATUS, 32'h0A);
      tick();
      chk_rd("status_err", ADDR_STATUS, 32'h24);
      chk_sig("tosw_err", to_sw_sig, 2);
      chk_rd("cycles_err", ADDR_CYCLES, 32'd3);
      bus_write(ADDR_CMD, 32'h2);
      chk_rd("status_err_ack", ADDR_STATUS, 32'h0);
      chk_sig("tosw_err_ack", to_sw_sig, 0);

      // timeout disabled, upper writedata bits ignored, abort in BUSY
      bus_write(ADDR_TIMEOUT, 32'h0);
      bus_write(ADDR_CMD, 32'hABCD_0005);
      chk_sig("start_upper_bits", eng_start, 1);
      repeat (8) tick();
      chk_rd("status_no_timeout", ADDR_STATUS, 32'h0A);
      drive_wr(ADDR_CMD, 32'h3);
      #1;
      chk_sig("abort_pulse", eng_abort, 1);
      tick();
      release_bus();
      chk_sig("abort_once", eng_abort, 0);
      chk_rd("status_aborted", ADDR_STATUS, 32'h0);
      chk_sig("tosw_aborted", to_sw_sig, 0);

      // abort during START is deferred into BUSY
      bus_write(ADDR_CMD, 32'h1);
      drive_wr(ADDR_CMD, 32'h3);
      #1;
      chk_sig("abort_in_start", eng_abort, 0);
      tick();
      release_bus();
      chk_sig("abort_deferred", eng_abort, 1);
      chk_rd("status_deferred", ADDR_STATUS, 32'h0A);
      tick();
      chk_rd("status_after_deferred", ADDR_STATUS, 32'h0);
      chk_sig("abort_deferred_once", eng_abort, 0);

      // done wins over timeout in the same cycle
      bus_write(ADDR_TIMEOUT, 32'h4);
      bus_write(ADDR_CMD, 32'h1);
      tick();
      repeat (4) tick();
      chk_rd("cycles_at_limit", ADDR_CYCLES, 32'd4);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk_rd("status_tie_done", ADDR_STATUS, 32'h13);
      chk_sig("tosw_tie_done", to_sw_sig, 1);
      chk_rd("cycles_tie", ADDR_CYCLES, 32'd4);
      bus_write(ADDR_CMD, 32'h2);

      // async reset mid-BUSY, concurrent abort write must not pulse
      bus_write(ADDR_TIMEOUT, 32'h7);
      bus_write(ADDR_CMD, 32'h1);
      repeat (3) tick();
      chk_rd("status_pre_reset", ADDR_STATUS, 32'h0A);
      drive_wr(ADDR_CMD, 32'h3);
      reset_n = 1'b0;
      #1;
      chk_sig("rst_mid_abort", eng_abort, 0);
      chk_sig("rst_mid_start", eng_start, 0);
      chk_sig("rst_mid_tosw", to_sw_sig, 0);
      release_bus();
      chk_rd("rst_mid_status", ADDR_STATUS, 32'h0);
      chk_rd("rst_mid_timeout", ADDR_TIMEOUT, 32'hFFFF);
      chk_rd("rst_mid_cycles", ADDR_CYCLES, 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      chk_rd("post_reset_status", ADDR_STATUS, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
